// File: rtl/usb2_ts_in_packer.sv
// usb2_ts_in_packer: packs a TS byte stream into USB IN endpoint packets, committing
// on a full packet, an explicit flush, or an idle timeout.
module usb2_ts_in_packer #(
    parameter int PKT_LEN = 512,
    parameter int TIMEOUT = 60000
) (
    input  logic        ext_clk,
    input  logic        reset,
    input  logic [7:0]  ts_data,
    input  logic        ts_valid,
    input  logic        ts_start,
    output logic        ts_ready,
    input  logic        flush,
    output logic [10:0] buf_in_addr,
    output logic [7:0]  buf_in_data,
    output logic        buf_in_wren,
    input  logic        buf_in_ready,
    output logic        buf_in_commit,
    output logic [10:0] buf_in_commit_len,
    input  logic        buf_in_commit_ack,
    output logic [15:0] stat_pkts,
    output logic [7:0]  err_sync
);
    typedef enum logic [1:0] {WAIT_BUF, FILL, COMMIT, ACK_LOW} state_t;
    state_t state, state_nx;
    logic [10:0] count, count_inc;
    logic [15:0] timer;
    logic accept, timeout_hit, go_commit, ack_seen;

    assign ts_ready    = state == FILL;
    assign accept      = ts_ready && ts_valid;
    assign count_inc   = count + 11'd1;
    assign timeout_hit = count != 11'd0 && timer == 16'(TIMEOUT - 1);
    // An accept landing with a flush or timeout is folded into that same commit.
    assign go_commit   = accept ? (count_inc == 11'(PKT_LEN) || flush || timeout_hit)
                                : (count != 11'd0 && (flush || timeout_hit));
    assign ack_seen    = buf_in_commit && buf_in_commit_ack;

    always_comb begin
        state_nx = state;
        case (state)
            WAIT_BUF: state_nx = buf_in_ready ? FILL : WAIT_BUF;
            FILL:     state_nx = go_commit ? COMMIT : FILL;
            COMMIT:   state_nx = ack_seen ? ACK_LOW : COMMIT;
            ACK_LOW:  state_nx = buf_in_commit_ack ? ACK_LOW : WAIT_BUF;
            default:  state_nx = WAIT_BUF;
        endcase
    end

    always_ff @(posedge ext_clk) begin
        if (reset) begin
            state             <= WAIT_BUF;
            count             <= '0;
            timer             <= '0;
            buf_in_addr       <= '0;
            buf_in_data       <= '0;
            buf_in_wren       <= 1'b0;
            buf_in_commit     <= 1'b0;
            buf_in_commit_len <= '0;
            stat_pkts         <= '0;
            err_sync          <= '0;
        end else begin
            state         <= state_nx;
            buf_in_wren   <= accept;
            // Commit rises one cycle after entering COMMIT, so never alongside the last wren.
            buf_in_commit <= state == COMMIT && !ack_seen;
            timer         <= (accept || state != FILL || count == 11'd0 || go_commit) ? 16'd0 : timer + 16'd1;
            if (state == WAIT_BUF && buf_in_ready)
                count <= '0;
            if (accept) begin
                buf_in_addr <= count;
                buf_in_data <= ts_data;
                count       <= count_inc;
                if (ts_start && ts_data != 8'h47 && err_sync != 8'hff)
                    err_sync <= err_sync + 8'd1;
            end
            if (state == FILL && go_commit)
                buf_in_commit_len <= accept ? count_inc : count;
            if (ack_seen)
                stat_pkts <= stat_pkts + 16'd1;
        end
    end
endmodule

// File: tb/tb_usb2_ts_in_packer.sv
// tb_usb2_ts_in_packer: directed bench with a write scoreboard for usb2_ts_in_packer.
module tb_usb2_ts_in_packer;
    logic        ext_clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  ts_data = '0;
    logic        ts_valid = 1'b0, ts_start = 1'b0, flush = 1'b0;
    logic        ts_ready;
    logic [10:0] buf_in_addr, buf_in_commit_len;
    logic [7:0]  buf_in_data, err_sync;
    logic        buf_in_wren, buf_in_commit;
    logic        buf_in_ready = 1'b0, buf_in_commit_ack = 1'b0;
    logic [15:0] stat_pkts;

    int checks = 0, errors = 0;
    logic [18:0] q[$];
    logic [10:0] exp_addr = '0;
    logic [15:0] exp_stat = '0;

    usb2_ts_in_packer #(.PKT_LEN(512), .TIMEOUT(100)) dut (
        .ext_clk(ext_clk), .reset(reset), .ts_data(ts_data), .ts_valid(ts_valid),
        .ts_start(ts_start), .ts_ready(ts_ready), .flush(flush),
        .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
        .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
        .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
        .stat_pkts(stat_pkts), .err_sync(err_sync)
    );

    always #5 ext_clk = ~ext_clk;

    // Every write strobe must match the oldest accepted byte, in order, and never coincide with commit.
    always @(negedge ext_clk) begin
        if (buf_in_wren) begin
            logic [18:0] exp;
            exp = (q.size() != 0) ? q.pop_front() : 19'h7ffff;
            checks++;
            assert ({buf_in_addr, buf_in_data} === exp && buf_in_commit === 1'b0) else begin
                errors++;
                $error("FAIL wren: got addr=%0d data=%h commit=%b, expected addr=%0d data=%h commit=0",
                       buf_in_addr, buf_in_data, buf_in_commit, exp[18:8], exp[7:0]);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic st, input logic fl);
        int n = 0;
        @(negedge ext_clk);
        ts_valid = 1'b1; ts_data = d; ts_start = st; flush = fl;
        while (!ts_ready && n < 400) begin
            @(negedge ext_clk);
            n++;
        end
        if (ts_ready) begin
            q.push_back({exp_addr, d});
            exp_addr++;
        end else chk("send ready timeout", 32'(ts_ready), 1);
    endtask

    task automatic idle();
        @(negedge ext_clk);
        ts_valid = 1'b0; ts_start = 1'b0; flush = 1'b0;
    endtask

    task automatic commit_check(input string tag, input int len, input bit hold_ack);
        for (int i = 0; i < 300 && !buf_in_commit; i++) @(negedge ext_clk);
        chk({tag, " commit"}, 32'(buf_in_commit), 1);
        chk({tag, " len"}, 32'(buf_in_commit_len), 32'(len));
        repeat (3) @(negedge ext_clk);
        chk({tag, " held"}, 32'(buf_in_commit), 1);
        buf_in_commit_ack = 1'b1;
        @(negedge ext_clk);
        exp_stat++;
        chk({tag, " commit drop"}, 32'(buf_in_commit), 0);
        chk({tag, " stat_pkts"}, 32'(stat_pkts), 32'(exp_stat));
        if (hold_ack) begin
            repeat (10) @(negedge ext_clk);
            chk({tag, " no fill while ack high"}, 32'(ts_ready), 0);
        end
        buf_in_commit_ack = 1'b0;
        exp_addr = '0;
    endtask

    initial begin
        repeat (3) @(negedge ext_clk);
        chk("rst ts_ready", 32'(ts_ready), 0);
        chk("rst wren", 32'(buf_in_wren), 0);
        chk("rst commit", 32'(buf_in_commit), 0);
        chk("rst addr", 32'(buf_in_addr), 0);
        chk("rst data", 32'(buf_in_data), 0);
        chk("rst len", 32'(buf_in_commit_len), 0);
        chk("rst stat", 32'(stat_pkts), 0);
        chk("rst err", 32'(err_sync), 0);
        reset = 1'b0;
        repeat (5) @(negedge ext_clk);
        chk("no buffer ts_ready", 32'(ts_ready), 0);
        buf_in_ready = 1'b1;

        // Full packet of 0..255 repeating
        for (int i = 0; i < 512; i++) send(8'(i), 1'b0, 1'b0);
        idle();
        commit_check("full", 512, 1'b0);

        // Four TS packets: 512 full, 240 left for the idle timeout
        for (int i = 0; i < 752; i++) begin
            send((i % 188 == 0) ? 8'h47 : 8'(i * 3), i % 188 == 0, 1'b0);
            if (i == 511) begin
                idle();
                commit_check("ts first", 512, 1'b0);
            end
        end
        idle();
        repeat (90) @(negedge ext_clk);
        chk("no early timeout", 32'(buf_in_commit), 0);
        commit_check("timeout", 240, 1'b0);
        chk("good sync no err", 32'(err_sync), 0);

        // Flush coincident with the 11th accept, then ack held high
        for (int i = 0; i < 10; i++) send(8'(8'hA0 + i), 1'b0, 1'b0);
        send(8'hEE, 1'b0, 1'b1);
        idle();
        commit_check("flush", 11, 1'b1);
        for (int i = 0; i < 20 && !ts_ready; i++) @(negedge ext_clk);
        chk("refill after ack low", 32'(ts_ready), 1);
        flush = 1'b1;
        @(negedge ext_clk);
        flush = 1'b0;
        repeat (20) @(negedge ext_clk);
        chk("empty flush no commit", 32'(buf_in_commit), 0);

        // Sync errors saturate
        for (int i = 0; i < 300; i++) send(8'h00, 1'b1, 1'b0);
        idle();
        @(negedge ext_clk);
        chk("err_sync sat", 32'(err_sync), 255);
        @(negedge ext_clk);
        flush = 1'b1;
        @(negedge ext_clk);
        flush = 1'b0;
        commit_check("sync flush", 300, 1'b0);

        // Reset while commit is pending
        for (int i = 0; i < 5; i++) send(8'h55, 1'b0, 1'b0);
        idle();
        flush = 1'b1;
        @(negedge ext_clk);
        flush = 1'b0;
        for (int i = 0; i < 20 && !buf_in_commit; i++) @(negedge ext_clk);
        chk("pending commit", 32'(buf_in_commit), 1);
        reset = 1'b1;
        @(negedge ext_clk);
        reset = 1'b0;
        chk("reset drops commit", 32'(buf_in_commit), 0);
        chk("reset stat", 32'(stat_pkts), 0);
        exp_stat = '0;
        exp_addr = '0;
        for (int i = 0; i < 3; i++) send(8'(8'h10 + i), 1'b0, 1'b0);
        idle();
        flush = 1'b1;
        @(negedge ext_clk);
        flush = 1'b0;
        commit_check("after reset", 3, 1'b0);

        repeat (3) @(negedge ext_clk);
        chk("scoreboard drained", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
